// File: rtl/v_alu_sequencer.sv
// VALU opcode/SEW encodings plus the sequencer that slices one full-register
// vector op into VALU-width chunks and reassembles the tail-undisturbed result.
package v_pkg;
   localparam logic [3:0] VALU_VADD = 4'd0;
   localparam logic [3:0] VALU_VSUB = 4'd1;
   localparam logic [3:0] VALU_VAND = 4'd2;
   localparam logic [3:0] VALU_VOR  = 4'd3;
   localparam logic [3:0] VALU_VXOR = 4'd4;

   localparam logic [1:0] VSEW_8  = 2'b00;
   localparam logic [1:0] VSEW_16 = 2'b01;
   localparam logic [1:0] VSEW_32 = 2'b10;
endpackage

module v_alu_sequencer
   import v_pkg::*;
#(
   parameter int VECTOR_LENGTH = 128,
   parameter int VALU_OP_W     = 32,
   parameter int ADDSUB_LAT    = 1,
   localparam int NCHUNK       = VECTOR_LENGTH / VALU_OP_W,
   localparam int VL_W         = $clog2(VECTOR_LENGTH / 8) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               op_instr,
   input  logic [1:0]               vsew,
   input  logic [VL_W-1:0]          vl,
   input  logic [VECTOR_LENGTH-1:0] vs1,
   input  logic [VECTOR_LENGTH-1:0] vs2,
   input  logic [VECTOR_LENGTH-1:0] vd_old,
   output logic [3:0]               valu_op_instr,
   output logic [1:0]               valu_vsew,
   output logic [VALU_OP_W-1:0]     valu_op_A,
   output logic [VALU_OP_W-1:0]     valu_op_B,
   output logic                     valu_issue,
   input  logic [VALU_OP_W-1:0]     valu_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [VECTOR_LENGTH-1:0] vd_out,
   output logic                     err,
   output logic                     busy
);

   localparam int BYTES = VECTOR_LENGTH / 8;
   localparam int CB    = VALU_OP_W / 8;
   localparam int CNT_W = $clog2(NCHUNK + ADDSUB_LAT + 1) + 1;
   localparam int CH_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                   state_reg, state_next;
   logic [3:0]               op_reg;
   logic [1:0]               vsew_reg;
   logic [VECTOR_LENGTH-1:0] vs1_reg, vs2_reg;
   logic [VECTOR_LENGTH-1:0] res_reg, res_next;
   logic [VL_W-1:0]          body_bytes_reg;
   logic [CNT_W-1:0]         nchunk_reg, lat_reg, cyc_reg;
   logic                     err_reg;
   logic [VALU_OP_W-1:0]     op_a_reg, op_b_reg;

   logic [VL_W-1:0]          vlmax, vl_clamp, body_bytes_in;
   logic                     illegal_sew;
   logic [CNT_W-1:0]         nchunk_in, lat_in;
   logic                     accept, cap_en;
   logic [CNT_W-1:0]         cap_idx;
   logic [CH_W-1:0]          next_idx;
   logic [BYTES-1:0]         byte_we;
   logic [VALU_OP_W-1:0]     vs1_ch [NCHUNK];
   logic [VALU_OP_W-1:0]     vs2_ch [NCHUNK];

   // Active work is measured in bytes so every SEW shares one merge mask.
   always_comb begin
      vlmax       = '0;
      illegal_sew = 1'b0;
      case (vsew)
         VSEW_8:  vlmax = VL_W'(BYTES);
         VSEW_16: vlmax = VL_W'(BYTES / 2);
         VSEW_32: vlmax = VL_W'(BYTES / 4);
         default: illegal_sew = 1'b1;
      endcase
      vl_clamp      = (vl > vlmax) ? vlmax : vl;
      body_bytes_in = vl_clamp << vsew;
      nchunk_in     = CNT_W'((int'(body_bytes_in) + CB - 1) / CB);
      lat_in        = (op_instr == VALU_VADD || op_instr == VALU_VSUB) ?
                      CNT_W'(ADDSUB_LAT) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      valu_issue = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         S_IDLE: begin
            busy     = 1'b0;
            in_ready = ~rst;
            if (in_valid && !rst) begin
               state_next = (nchunk_in == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            valu_issue = 1'b1;
            if (cyc_reg == nchunk_reg - 1'b1) begin
               state_next = (lat_reg == '0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cyc_reg == nchunk_reg - 1'b1 + lat_reg) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign accept   = in_valid & in_ready;
   // Results trail issue by the opcode latency, so the captured chunk is cyc - L.
   assign cap_en   = (state_reg == S_ISSUE || state_reg == S_DRAIN) && (cyc_reg >= lat_reg);
   assign cap_idx  = cyc_reg - lat_reg;
   assign next_idx = CH_W'(cyc_reg + 1'b1);

   genvar gi;
   generate
      for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign vs1_ch[gi] = vs1_reg[gi*VALU_OP_W +: VALU_OP_W];
         assign vs2_ch[gi] = vs2_reg[gi*VALU_OP_W +: VALU_OP_W];
      end
      for (gi = 0; gi < BYTES; gi++) begin : g_byte_we
         assign byte_we[gi] = cap_en && (cap_idx == CNT_W'(gi / CB)) &&
                              (VL_W'(gi) < body_bytes_reg);
      end
   endgenerate

   // Tail bytes are never written, so the vd_old preload survives there.
   always_comb begin
      res_next = res_reg;
      for (int b = 0; b < BYTES; b++) begin
         if (byte_we[b]) begin
            res_next[b*8 +: 8] = valu_result[(b % CB)*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg         <= '0;
         vsew_reg       <= '0;
         vs1_reg        <= '0;
         vs2_reg        <= '0;
         res_reg        <= '0;
         body_bytes_reg <= '0;
         nchunk_reg     <= '0;
         lat_reg        <= '0;
         cyc_reg        <= '0;
         err_reg        <= 1'b0;
         op_a_reg       <= '0;
         op_b_reg       <= '0;
      end else if (accept) begin
         op_reg         <= op_instr;
         vsew_reg       <= vsew;
         vs1_reg        <= vs1;
         vs2_reg        <= vs2;
         res_reg        <= vd_old;
         body_bytes_reg <= body_bytes_in;
         nchunk_reg     <= nchunk_in;
         lat_reg        <= lat_in;
         cyc_reg        <= '0;
         err_reg        <= illegal_sew;
         if (nchunk_in != '0) begin
            op_a_reg <= vs2[VALU_OP_W-1:0];
            op_b_reg <= vs1[VALU_OP_W-1:0];
         end
      end else if (state_reg == S_ISSUE || state_reg == S_DRAIN) begin
         cyc_reg <= cyc_reg + 1'b1;
         res_reg <= res_next;
         if (state_reg == S_ISSUE && state_next == S_ISSUE) begin
            op_a_reg <= vs2_ch[next_idx];
            op_b_reg <= vs1_ch[next_idx];
         end
      end
   end

   assign valu_op_instr = op_reg;
   assign valu_vsew     = vsew_reg;
   assign valu_op_A     = op_a_reg;
   assign valu_op_B     = op_b_reg;
   assign vd_out        = res_reg;
   assign err           = err_reg;

endmodule

// File: tb/tb_v_alu_sequencer.sv
// Scoreboard bench for v_alu_sequencer with a behavioural 32-bit VALU attached.
module tb_v_alu_sequencer;
   import v_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   op_instr = '0;
   logic [1:0]   vsew = '0;
   logic [4:0]   vl = '0;
   logic [127:0] vs1 = '0, vs2 = '0, vd_old = '0;
   logic [3:0]   valu_op_instr;
   logic [1:0]   valu_vsew;
   logic [31:0]  valu_op_A, valu_op_B, valu_result;
   logic         valu_issue;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] vd_out;
   logic         err, busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [127:0] vd;
      logic         err;
      int           issues;
      int           cyc;
   } exp_t;
   exp_t sb[$];

   v_alu_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_instr(op_instr), .vsew(vsew), .vl(vl), .vs1(vs1), .vs2(vs2),
      .vd_old(vd_old), .valu_op_instr(valu_op_instr), .valu_vsew(valu_vsew),
      .valu_op_A(valu_op_A), .valu_op_B(valu_op_B), .valu_issue(valu_issue),
      .valu_result(valu_result), .out_valid(out_valid), .out_ready(out_ready),
      .vd_out(vd_out), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural VALU: lane-wise add/sub registered once, logic ops combinational.
   function automatic logic [31:0] lane_as(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] sew, input logic sub);
      logic [31:0] r;
      r = '0;
      case (sew)
         2'b00: for (int i = 0; i < 4; i++)
                   r[i*8 +: 8] = sub ? a[i*8 +: 8] - b[i*8 +: 8] : a[i*8 +: 8] + b[i*8 +: 8];
         2'b01: for (int i = 0; i < 2; i++)
                   r[i*16 +: 16] = sub ? a[i*16 +: 16] - b[i*16 +: 16] : a[i*16 +: 16] + b[i*16 +: 16];
         default: r = sub ? a - b : a + b;
      endcase
      return r;
   endfunction

   logic [31:0] addsub_q = '0;
   always @(posedge clk)
      addsub_q <= lane_as(valu_op_A, valu_op_B, valu_vsew, valu_op_instr == VALU_VSUB);

   always_comb begin
      valu_result = '0;
      case (valu_op_instr)
         VALU_VADD, VALU_VSUB: valu_result = addsub_q;
         VALU_VAND:            valu_result = valu_op_A & valu_op_B;
         VALU_VOR:             valu_result = valu_op_A | valu_op_B;
         VALU_VXOR:            valu_result = valu_op_A ^ valu_op_B;
         default:              valu_result = '0;
      endcase
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: cycle 0 is the first negedge after the accept edge.
   bit mon_inflight = 0;
   bit mon_seen     = 0;
   int mon_cyc      = 0;
   int mon_iss      = 0;
   always @(negedge clk) begin
      if (rst) begin
         mon_inflight = 0;
      end else begin
         if (mon_inflight) begin
            if (valu_issue) mon_iss++;
            if (out_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 128'(out_valid), 128'(0));
               end else begin
                  if (!mon_seen) begin
                     chk("out_valid_cycle", 128'(mon_cyc), 128'(sb[0].cyc));
                     chk("issue_count", 128'(mon_iss), 128'(sb[0].issues));
                  end
                  mon_seen = 1;
                  chk("vd_out", vd_out, sb[0].vd);
                  chk("err", 128'(err), 128'(sb[0].err));
                  chk("in_ready_in_done", 128'(in_ready), 128'(0));
                  if (out_ready) begin
                     $display("txn done: vd_out=%h err=%0d cycle=%0d issues=%0d",
                              vd_out, err, mon_cyc, mon_iss);
                     void'(sb.pop_front());
                     mon_inflight = 0;
                  end
               end
            end
            mon_cyc++;
         end else begin
            chk("no_stale_out_valid", 128'(out_valid), 128'(0));
         end
         if (in_valid && in_ready) begin
            mon_inflight = 1;
            mon_seen     = 0;
            mon_cyc      = 0;
            mon_iss      = 0;
         end
      end
   end

   // Called at #1 after a posedge; returns #1 after the accept edge.
   task automatic start_op(input logic [3:0] op, input logic [1:0] sew, input logic [4:0] l,
                           input logic [127:0] b1, input logic [127:0] a2, input logic [127:0] old,
                           input logic [127:0] e_vd, input logic e_err, input int e_iss,
                           input int e_cyc, input bit push);
      int n;
      op_instr = op; vsew = sew; vl = l; vs1 = b1; vs2 = a2; vd_old = old;
      in_valid = 1'b1;
      if (push) sb.push_back('{e_vd, e_err, e_iss, e_cyc});
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready=%0d required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy || sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL idle_timeout: busy=%0d pending=%0d required 0", busy, sb.size());
      end
   endtask

   initial begin
      int n;
      // Reset state
      #12;
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_vd_out", vd_out, 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_issue", 128'(valu_issue), 128'(0));
      chk("rst_op_AB", {valu_op_A, valu_op_B}, 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset mid-ISSUE of a VADD
      start_op(VALU_VADD, VSEW_8, 5'd16, {16{8'h7F}}, {16{8'h01}}, '0, '0, 1'b0, 0, 0, 0);
      @(posedge clk); #1;
      chk("mid_issue_active", 128'(valu_issue), 128'(1));
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 128'(out_valid), 128'(0));
      chk("arst_busy", 128'(busy), 128'(0));
      chk("arst_issue", 128'(valu_issue), 128'(0));
      chk("arst_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;

      // VADD SEW8 full length
      start_op(VALU_VADD, VSEW_8, 5'd16, {16{8'h7F}}, {16{8'h01}}, {16{8'h55}},
               {16{8'h80}}, 1'b0, 4, 5, 1);
      wait_idle();
      // VXOR SEW32 vl=2
      start_op(VALU_VXOR, VSEW_32, 5'd2, {4{32'hFFFFFFFF}}, {4{32'h0F0F0F0F}}, {4{32'hAAAAAAAA}},
               128'hAAAAAAAA_AAAAAAAA_F0F0F0F0_F0F0F0F0, 1'b0, 2, 2, 1);
      wait_idle();
      // VSUB SEW16 vl=5 with per-lane borrow
      start_op(VALU_VSUB, VSEW_16, 5'd5, {8{16'h0003}},
               128'h0008_0007_0006_0005_0004_0003_0002_0001, {8{16'hBEEF}},
               128'hBEEF_BEEF_BEEF_0002_0001_0000_FFFF_FFFE, 1'b0, 3, 4, 1);
      wait_idle();
      // vl=0
      start_op(VALU_VADD, VSEW_8, 5'd0, {16{8'hFF}}, {16{8'hFF}},
               128'h0123456789ABCDEF_FEDCBA9876543210,
               128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 0, 0, 1);
      wait_idle();
      // Illegal vsew
      start_op(VALU_VXOR, 2'b11, 5'd4, {16{8'hFF}}, {16{8'h0F}}, {4{32'h13579BDF}},
               {4{32'h13579BDF}}, 1'b1, 0, 0, 1);
      wait_idle();
      // vl above VLMAX is clamped
      start_op(VALU_VAND, VSEW_32, 5'd31, 128'h0000FFFF_FFFFFFFF_0F0F0F0F_FFFF0000,
               128'hFFFF0000_12345678_F0F0F0F0_DEADBEEF, '0,
               128'h00000000_12345678_00000000_DEAD0000, 1'b0, 4, 4, 1);
      wait_idle();
      // Partial first chunk: only bytes 0..2 active
      start_op(VALU_VOR, VSEW_8, 5'd3, {4{32'h80000000}}, {4{32'h11223344}}, {4{32'hCCCCCCCC}},
               128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CC223344, 1'b0, 1, 1, 1);
      wait_idle();

      // Back-pressure: hold DONE 6 cycles with the next request waiting
      out_ready = 1'b0;
      start_op(VALU_VXOR, VSEW_32, 5'd2, {4{32'hFFFFFFFF}}, {4{32'h0F0F0F0F}}, {4{32'hAAAAAAAA}},
               128'hAAAAAAAA_AAAAAAAA_F0F0F0F0_F0F0F0F0, 1'b0, 2, 2, 1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_reached_done", 128'(out_valid), 128'(1));
      fork
         start_op(VALU_VADD, VSEW_32, 5'd4,
                  128'h0000FFFF_00000010_7FFFFFFF_FFFFFFFF, {4{32'h00000001}}, '0,
                  128'h00010000_00000011_80000000_00000000, 1'b0, 4, 5, 1);
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_idle();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
